// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline datapath and hazard_stall_unit.
// The pipeline side is the master: it reports hazard sources and receives the load/flush controls.
interface hazard_stall_unit_if;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rd;
    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic       if_id_uses_rs1;
    logic       if_id_uses_rs2;
    logic       br_redirect;
    logic       ld_pc;
    logic       ld_if_id;
    logic       ld_id_ex;
    logic       ld_ex_mem;
    logic       ld_mem_wb;
    logic       flush_if_id;
    logic       bubble_id_ex;

    modport master (
        output imem_resp, dmem_req, dmem_resp, id_ex_mem_read, id_ex_rd,
               if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2, br_redirect,
        input  ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, flush_if_id, bubble_id_ex
    );

    modport slave (
        input  imem_resp, dmem_req, dmem_resp, id_ex_mem_read, id_ex_rd,
               if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2, br_redirect,
        output ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, flush_if_id, bubble_id_ex
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: memory-wait freezes, branch redirect flushes and load-use bubbles,
// with saturating stall/bubble cycle counters. Controls are combinational (zero added latency).
module hazard_stall_unit #(
    parameter int CNT_W      = 32,
    parameter int LU_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    hazard_stall_unit_if.slave hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles
);
    typedef enum logic [1:0] {RUN, FREEZE, LU_HOLD} state_t;

    localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

    state_t     state, next_state;
    logic       redirect_pending, next_pending;
    logic [1:0] lu_cnt, next_lu;
    logic       mem_wait, lu_hazard, hold_active, freeze;
    logic       ld_pc_c, ld_if_id_c, ld_back_c, flush_c, bubble_c;

    assign mem_wait  = (hz.dmem_req & ~hz.dmem_resp) | ~hz.imem_resp;
    assign lu_hazard = hz.id_ex_mem_read & (hz.id_ex_rd != 5'd0) &
                       ((hz.if_id_uses_rs1 & (hz.if_id_rs1 == hz.id_ex_rd)) |
                        (hz.if_id_uses_rs2 & (hz.if_id_rs2 == hz.id_ex_rd)));
    // A freeze that interrupted a load-use hold resumes the hold via the retained lu_cnt.
    assign hold_active = (state == LU_HOLD) || (state == FREEZE && lu_cnt != 2'd0);

    always_comb begin
        next_state   = state;
        next_pending = redirect_pending;
        next_lu      = lu_cnt;
        freeze       = 1'b0;
        ld_pc_c      = 1'b1;
        ld_if_id_c   = 1'b1;
        ld_back_c    = 1'b1;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        if (mem_wait) begin
            freeze     = 1'b1;
            ld_pc_c    = 1'b0;
            ld_if_id_c = 1'b0;
            ld_back_c  = 1'b0;
            next_state = FREEZE;
            if (hz.br_redirect) next_pending = 1'b1;
        end else if (hz.br_redirect || redirect_pending) begin
            flush_c      = 1'b1;
            bubble_c     = 1'b1;
            next_pending = 1'b0;
            next_lu      = 2'd0;
            next_state   = RUN;
        end else if (hold_active) begin
            ld_pc_c    = 1'b0;
            ld_if_id_c = 1'b0;
            bubble_c   = 1'b1;
            next_lu    = lu_cnt - 2'd1;
            next_state = (lu_cnt == 2'd1) ? RUN : LU_HOLD;
        end else if (lu_hazard) begin
            ld_pc_c    = 1'b0;
            ld_if_id_c = 1'b0;
            bubble_c   = 1'b1;
            next_lu    = LU_INIT;
            next_state = (LU_INIT != 2'd0) ? LU_HOLD : RUN;
        end else begin
            next_state = RUN;
        end
    end

    // Reset forces every control low immediately, independent of the inputs.
    always_comb begin
        hz.ld_pc        = rst & ld_pc_c;
        hz.ld_if_id     = rst & ld_if_id_c;
        hz.ld_id_ex     = rst & ld_back_c;
        hz.ld_ex_mem    = rst & ld_back_c;
        hz.ld_mem_wb    = rst & ld_back_c;
        hz.flush_if_id  = rst & flush_c;
        hz.bubble_id_ex = rst & bubble_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= RUN;
            redirect_pending <= 1'b0;
            lu_cnt           <= 2'd0;
            stall_cycles     <= '0;
            bubble_cycles    <= '0;
        end else begin
            state            <= next_state;
            redirect_pending <= next_pending;
            lu_cnt           <= next_lu;
            if (freeze && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (bubble_c && bubble_cycles != '1)
                bubble_cycles <= bubble_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: dut A uses defaults, dut B uses
// LU_BUBBLES=2 with a 3-bit counter to reach saturation quickly.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [31:0] stall_a, bubble_a;
    logic [2:0]  stall_b, bubble_b;
    int n_chk = 0;
    int n_fail = 0;

    // {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, flush_if_id, bubble_id_ex}
    localparam logic [6:0] RUN_V = 7'b1111100;
    localparam logic [6:0] FRZ_V = 7'b0000000;
    localparam logic [6:0] LU_V  = 7'b0011101;
    localparam logic [6:0] RDR_V = 7'b1111111;

    hazard_stall_unit_if ia();
    hazard_stall_unit_if ib();

    hazard_stall_unit dut_a (
        .clk(clk), .rst(rst_a), .hz(ia),
        .stall_cycles(stall_a), .bubble_cycles(bubble_a)
    );

    hazard_stall_unit #(.CNT_W(3), .LU_BUBBLES(2)) dut_b (
        .clk(clk), .rst(rst_b), .hz(ib),
        .stall_cycles(stall_b), .bubble_cycles(bubble_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_a();
        return {ia.ld_pc, ia.ld_if_id, ia.ld_id_ex, ia.ld_ex_mem, ia.ld_mem_wb,
                ia.flush_if_id, ia.bubble_id_ex};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {ib.ld_pc, ib.ld_if_id, ib.ld_id_ex, ib.ld_ex_mem, ib.ld_mem_wb,
                ib.flush_if_id, ib.bubble_id_ex};
    endfunction

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_a();
        ia.imem_resp = 1'b1; ia.dmem_req = 1'b0; ia.dmem_resp = 1'b0;
        ia.id_ex_mem_read = 1'b0; ia.id_ex_rd = 5'd0;
        ia.if_id_rs1 = 5'd0; ia.if_id_rs2 = 5'd0;
        ia.if_id_uses_rs1 = 1'b0; ia.if_id_uses_rs2 = 1'b0; ia.br_redirect = 1'b0;
    endtask

    task automatic idle_b();
        ib.imem_resp = 1'b1; ib.dmem_req = 1'b0; ib.dmem_resp = 1'b0;
        ib.id_ex_mem_read = 1'b0; ib.id_ex_rd = 5'd0;
        ib.if_id_rs1 = 5'd0; ib.if_id_rs2 = 5'd0;
        ib.if_id_uses_rs1 = 1'b0; ib.if_id_uses_rs2 = 1'b0; ib.br_redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        idle_a(); idle_b();
        cyc(); #1;
        n_chk++;
        if (ctl_a() !== FRZ_V) begin n_fail++; $display("FAIL reset_ctl_a: got %b want %b", ctl_a(), FRZ_V); end
        n_chk++;
        if (ctl_b() !== FRZ_V) begin n_fail++; $display("FAIL reset_ctl_b: got %b want %b", ctl_b(), FRZ_V); end
        n_chk++;
        if (stall_a !== 32'd0 || bubble_a !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt_a: got %0d/%0d want 0/0", stall_a, bubble_a);
        end
        cyc(); rst_a = 1'b1; rst_b = 1'b1; #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL reset_release: got %b want %b", ctl_a(), RUN_V); end
    endtask

    task automatic test_load_use();
        cyc();
        ia.id_ex_mem_read = 1'b1; ia.id_ex_rd = 5'd5;
        ia.if_id_rs1 = 5'd5; ia.if_id_rs2 = 5'd1; ia.if_id_uses_rs1 = 1'b1; ia.if_id_uses_rs2 = 1'b1;
        #1;
        n_chk++;
        if (ctl_a() !== LU_V) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", ctl_a(), LU_V); end
        cyc(); idle_a(); #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL lu_resume: got %b want %b", ctl_a(), RUN_V); end
        n_chk++;
        if (bubble_a !== 32'd1) begin n_fail++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_a); end
    endtask

    task automatic test_no_hazard();
        cyc();
        ia.id_ex_mem_read = 1'b1; ia.id_ex_rd = 5'd0; ia.if_id_rs1 = 5'd0; ia.if_id_uses_rs1 = 1'b1;
        #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL x0_no_stall: got %b want %b", ctl_a(), RUN_V); end
        cyc();
        ia.id_ex_rd = 5'd5; ia.if_id_rs1 = 5'd5; ia.if_id_uses_rs1 = 1'b0;
        ia.if_id_rs2 = 5'd7; ia.if_id_uses_rs2 = 1'b1;
        #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL unused_rs1: got %b want %b", ctl_a(), RUN_V); end
        cyc(); idle_a(); #1;
        n_chk++;
        if (bubble_a !== 32'd1) begin n_fail++; $display("FAIL no_hazard_cnt: got %0d want 1", bubble_a); end
        ia.id_ex_mem_read = 1'b1; ia.id_ex_rd = 5'd9; ia.if_id_rs2 = 5'd9; ia.if_id_uses_rs2 = 1'b1;
        #1;
        n_chk++;
        if (ctl_a() !== LU_V) begin n_fail++; $display("FAIL rs2_hazard: got %b want %b", ctl_a(), LU_V); end
        cyc(); idle_a(); #1;
        n_chk++;
        if (bubble_a !== 32'd2) begin n_fail++; $display("FAIL rs2_bubble_cnt: got %0d want 2", bubble_a); end
    endtask

    task automatic test_dmem_wait();
        cyc();
        ia.dmem_req = 1'b1; ia.dmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) cyc();
            #1;
            n_chk++;
            if (ctl_a() !== FRZ_V) begin n_fail++; $display("FAIL dmem_freeze[%0d]: got %b want %b", i, ctl_a(), FRZ_V); end
        end
        cyc(); ia.dmem_resp = 1'b1; #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL dmem_done: got %b want %b", ctl_a(), RUN_V); end
        n_chk++;
        if (stall_a !== 32'd4) begin n_fail++; $display("FAIL dmem_stall_cnt: got %0d want 4", stall_a); end
        cyc(); idle_a();
    endtask

    task automatic test_redirect_in_freeze();
        ia.dmem_req = 1'b1; ia.dmem_resp = 1'b0; #1;
        n_chk++;
        if (ctl_a() !== FRZ_V) begin n_fail++; $display("FAIL rf_freeze0: got %b want %b", ctl_a(), FRZ_V); end
        cyc(); ia.br_redirect = 1'b1; #1;
        n_chk++;
        if (ctl_a() !== FRZ_V) begin n_fail++; $display("FAIL rf_freeze1: got %b want %b", ctl_a(), FRZ_V); end
        cyc(); ia.br_redirect = 1'b0; #1;
        n_chk++;
        if (ctl_a() !== FRZ_V) begin n_fail++; $display("FAIL rf_freeze2: got %b want %b", ctl_a(), FRZ_V); end
        cyc(); ia.dmem_resp = 1'b1; #1;
        n_chk++;
        if (ctl_a() !== RDR_V) begin n_fail++; $display("FAIL rf_flush: got %b want %b", ctl_a(), RDR_V); end
        cyc(); idle_a(); #1;
        n_chk++;
        if (ctl_a() !== RUN_V) begin n_fail++; $display("FAIL rf_after: got %b want %b", ctl_a(), RUN_V); end
        n_chk++;
        if (stall_a !== 32'd7 || bubble_a !== 32'd3) begin
            n_fail++; $display("FAIL rf_counts: got %0d/%0d want 7/3", stall_a, bubble_a);
        end
    endtask

    task automatic test_lu2();
        cyc();
        ib.id_ex_mem_read = 1'b1; ib.id_ex_rd = 5'd5; ib.if_id_rs1 = 5'd5; ib.if_id_uses_rs1 = 1'b1;
        #1;
        n_chk++;
        if (ctl_b() !== LU_V) begin n_fail++; $display("FAIL lu2_first: got %b want %b", ctl_b(), LU_V); end
        cyc(); idle_b(); #1;
        n_chk++;
        if (ctl_b() !== LU_V) begin n_fail++; $display("FAIL lu2_hold: got %b want %b", ctl_b(), LU_V); end
        cyc(); #1;
        n_chk++;
        if (ctl_b() !== RUN_V) begin n_fail++; $display("FAIL lu2_done: got %b want %b", ctl_b(), RUN_V); end
        n_chk++;
        if (bubble_b !== 3'd2) begin n_fail++; $display("FAIL lu2_bubble_cnt: got %0d want 2", bubble_b); end
    endtask

    task automatic test_redirect_vs_lu();
        cyc();
        ib.id_ex_mem_read = 1'b1; ib.id_ex_rd = 5'd5; ib.if_id_rs1 = 5'd5; ib.if_id_uses_rs1 = 1'b1;
        ib.br_redirect = 1'b1;
        #1;
        n_chk++;
        if (ctl_b() !== RDR_V) begin n_fail++; $display("FAIL rdr_vs_lu: got %b want %b", ctl_b(), RDR_V); end
        cyc(); idle_b(); #1;
        n_chk++;
        if (ctl_b() !== RUN_V) begin n_fail++; $display("FAIL rdr_no_hold: got %b want %b", ctl_b(), RUN_V); end
        n_chk++;
        if (bubble_b !== 3'd3) begin n_fail++; $display("FAIL rdr_bubble_cnt: got %0d want 3", bubble_b); end
    endtask

    task automatic test_saturation();
        cyc(); ib.imem_resp = 1'b0;
        repeat (9) cyc();
        ib.imem_resp = 1'b1; #1;
        n_chk++;
        if (stall_b !== 3'd7) begin n_fail++; $display("FAIL stall_saturate: got %0d want 7", stall_b); end
        n_chk++;
        if (ctl_b() !== RUN_V) begin n_fail++; $display("FAIL sat_resume: got %b want %b", ctl_b(), RUN_V); end
    endtask

    task automatic test_reset_mid_hold();
        cyc();
        ib.id_ex_mem_read = 1'b1; ib.id_ex_rd = 5'd3; ib.if_id_rs2 = 5'd3; ib.if_id_uses_rs2 = 1'b1;
        #1;
        n_chk++;
        if (ctl_b() !== LU_V) begin n_fail++; $display("FAIL rmh_first: got %b want %b", ctl_b(), LU_V); end
        cyc(); idle_b(); rst_b = 1'b0; #1;
        n_chk++;
        if (ctl_b() !== FRZ_V) begin n_fail++; $display("FAIL rmh_outputs: got %b want %b", ctl_b(), FRZ_V); end
        n_chk++;
        if (stall_b !== 3'd0 || bubble_b !== 3'd0) begin
            n_fail++; $display("FAIL rmh_counters: got %0d/%0d want 0/0", stall_b, bubble_b);
        end
        cyc(); rst_b = 1'b1; #1;
        n_chk++;
        if (ctl_b() !== RUN_V) begin n_fail++; $display("FAIL rmh_release: got %b want %b", ctl_b(), RUN_V); end
        cyc(); #1;
        n_chk++;
        if (ctl_b() !== RUN_V || bubble_b !== 3'd0) begin
            n_fail++; $display("FAIL rmh_run: got %b/%0d want %b/0", ctl_b(), bubble_b, RUN_V);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_dmem_wait();
        test_redirect_in_freeze();
        test_lu2();
        test_redirect_vs_lu();
        test_saturation();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It handles the hazards that operand forwarding cannot resolve: load-use dependences, instruction/data memory wait states, and control-flow redirects.
- It drives the load enables of the PC and the four pipeline registers, plus the flush/bubble controls.
- It sits beside the forwarding logic: forwarding consumes results, and this block decides when results cannot be consumed yet.
- It keeps saturating performance counters for stall and bubble cycles.

Parameters:
CNT_W, 32, width of the stall_cycles and bubble_cycles counters
LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (legal range 1..3)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
imem_resp  input  1  instruction fetch for the current PC completes this cycle
dmem_req  input  1  EX/MEM instruction is a load or store (read or write strobe)
dmem_resp  input  1  data memory access completes this cycle
id_ex_mem_read  input  1  ID/EX holds a load
id_ex_rd  input  5  destination register of the ID/EX instruction
if_id_rs1  input  5  rs1 field of the IF/ID instruction
if_id_rs2  input  5  rs2 field of the IF/ID instruction
if_id_uses_rs1  input  1  IF/ID instruction reads rs1
if_id_uses_rs2  input  1  IF/ID instruction reads rs2
br_redirect  input  1  taken branch/jump resolved in EX/MEM; PC is being redirected
ld_pc  output  1  PC load enable
ld_if_id  output  1  IF/ID load enable
ld_id_ex  output  1  ID/EX load enable
ld_ex_mem  output  1  EX/MEM load enable
ld_mem_wb  output  1  MEM/WB load enable
flush_if_id  output  1  replace the IF/ID contents with a NOP on this edge
bubble_id_ex  output  1  load a NOP into ID/EX on this edge instead of the decoded instruction
stall_cycles  output  CNT_W  count of freeze cycles, saturating
bubble_cycles  output  CNT_W  count of cycles with bubble_id_ex=1, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, redirect_pending=0, lu_cnt=0, counters=0.
  - All ld_* outputs = 0; flush_if_id = 0; bubble_id_ex = 0.
- Combinational terms:
  - mem_wait = (dmem_req & ~dmem_resp) | ~imem_resp.
  - lu_hazard = id_ex_mem_read & (id_ex_rd != 0) & ((if_id_uses_rs1 & if_id_rs1 == id_ex_rd) | (if_id_uses_rs2 & if_id_rs2 == id_ex_rd)).
- Register x0 never causes a hazard.
- States: RUN, FREEZE, LU_HOLD. Priority each cycle: freeze > redirect > load-use.
- FREEZE condition (any state, mem_wait=1):
  - All ld_* = 0; flush and bubble = 0; stall_cycles increments.
  - br_redirect=1 during a freeze sets redirect_pending=1. It is held until applied and never lost.
  - lu_cnt holds its value.
  - When mem_wait deasserts, the next state is RUN, or LU_HOLD if lu_cnt != 0.
- Redirect (mem_wait=0 and (br_redirect | redirect_pending)):
  - All ld_* = 1; flush_if_id = 1; bubble_id_ex = 1.
  - Clears redirect_pending and lu_cnt; next state is RUN.
  - A load-use hazard in the same cycle is discarded, because the younger instruction is squashed.
- Load-use detected in RUN (mem_wait=0, no redirect, lu_hazard=1):
  - ld_pc = 0; ld_if_id = 0; ld_id_ex = 1 with bubble_id_ex = 1; ld_ex_mem = ld_mem_wb = 1.
  - lu_cnt = LU_BUBBLES-1. Next state is LU_HOLD if lu_cnt != 0, else RUN.
- LU_HOLD (mem_wait=0, no redirect):
  - Same outputs as the load-use cycle; lu_cnt decrements.
  - Returns to RUN when lu_cnt reaches 0.
  - lu_hazard is not re-evaluated in LU_HOLD.
- RUN with no event: all ld_* = 1; flush and bubble = 0.
- Counter rules:
  - bubble_cycles increments whenever bubble_id_ex=1.
  - Both counters saturate at all-ones and never wrap.
  - The counters are not reset by a redirect.
- Outputs are combinational from the inputs and state; the block adds zero latency to the pipeline.
- Reset asserted mid-freeze or mid-LU_HOLD discards pending work immediately.

Test Plan:
- Load x5 in ID/EX, IF/ID add x6,x5,x1 (uses_rs1=1), memories ready -> one cycle with ld_pc=0, ld_if_id=0, bubble_id_ex=1; next cycle all ld_*=1; bubble_cycles=1.
- Same stimulus but id_ex_rd=0, or uses_rs1=0 with rs1 matching -> no stall; all ld_*=1 and bubble_cycles stays 0.
- dmem_req=1, dmem_resp held 0 for 4 cycles then 1 -> all ld_*=0 for 4 cycles; stall_cycles=4; normal flow afterwards.
- br_redirect=1 pulsed during the second cycle of a 3-cycle dmem wait -> no flush during the freeze; flush_if_id=1 and bubble_id_ex=1 on the first unfrozen cycle only.
- br_redirect=1 and lu_hazard=1 in the same cycle -> flush_if_id=1, bubble_id_ex=1, ld_pc=1; no load-use hold the following cycle.
- LU_BUBBLES=2 with a load-use hazard; assert rst=0 after the first bubble -> outputs go to 0 at once; after release state=RUN and counters=0.
